// File: rtl/key_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// key_conditioner_pkg
// Shared game package: key count, default key timing constants, the
// game-state encodings used by the surrounding game logic, and small
// elaboration-time helper functions for sizing counters.
// -----------------------------------------------------------------------------
package key_conditioner_pkg;

  // Number of physical push-buttons handled by the key conditioner.
  localparam int unsigned KEY_COUNT = 32'd4;

  // Index of the game-start key inside the key vector.
  localparam int unsigned KEY_START_IDX = 32'd3;

  // Default timing, in clock cycles at 50 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1000000;   // 20 ms
  localparam int unsigned DEFAULT_REPEAT_DELAY    = 32'd25000000;  // 500 ms
  localparam int unsigned DEFAULT_REPEAT_PERIOD   = 32'd5000000;   // 100 ms

  // Top-level game-state encodings.
  typedef enum logic [1:0] {
    GS_IDLE  = 2'd0,
    GS_PLAY  = 2'd1,
    GS_PAUSE = 2'd2,
    GS_OVER  = 2'd3
  } game_state_e;

  // Larger of two unsigned values, used to size the shared repeat counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Bits needed for a counter that runs 0 .. n-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/key_conditioner_key_channel.sv
// -----------------------------------------------------------------------------
// key_channel
// Conditioning for a single push-button: two-flop synchronizer, debounce
// counter, press/release edge pulses and auto-repeat pulses.
//
// Ports
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   enable      in   1 = pulse outputs allowed; 0 = pulses forced low and
//                    the repeat counter held clear
//   key_n       in   raw active-low button, asynchronous to clock
//   key_down    out  debounced level, 1 = held
//   key_press   out  one-cycle pulse in the first cycle key_down reads 1
//   key_release out  one-cycle pulse in the first cycle key_down reads 0
//   key_repeat  out  one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module key_channel
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic key_n,
  output logic key_down,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RP_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [DB_W-1:0] DB_ZERO    = DB_W'(1'b0);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1'b1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [RP_W-1:0] RP_ZERO    = RP_W'(1'b0);
  localparam logic [RP_W-1:0] RP_ONE     = RP_W'(1'b1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 32'd1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 32'd1);

  // Synchronizer stages.
  logic sync_meta_q, sync_meta_d;
  logic sync_q, sync_d;

  // Debounce state.
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            down_q, down_d;

  // Repeat state: rep_phase_q = 0 while waiting for the first repeat,
  // 1 once the periodic phase has started.
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_phase_q, rep_phase_d;
  logic [RP_W-1:0] rep_last;

  // Registered pulse outputs.
  logic press_q, press_d;
  logic release_q, release_d;
  logic repeat_q, repeat_d;

  // Debounced level flips at this edge.
  logic toggle;
  logic rise;
  logic fall;

  // Synchronizer next-state: the raw input is inverted so sync is active-high.
  always_comb begin
    sync_meta_d = ~key_n;
    sync_d      = sync_meta_q;
  end

  // Debounce next-state: count while the synchronized level disagrees with
  // the accepted level, accept it once it has disagreed for the full window.
  always_comb begin
    db_cnt_d = db_cnt_q;
    down_d   = down_q;
    toggle   = 1'b0;
    if (sync_q == down_q) begin
      db_cnt_d = DB_ZERO;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d = DB_ZERO;
      down_d   = ~down_q;
      toggle   = 1'b1;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end
  end

  // Edge pulses: set at the same edge that flips key_down, so each pulse is
  // high in exactly the first cycle the new level is visible.
  always_comb begin
    rise      = toggle & ~down_q;
    fall      = toggle & down_q;
    press_d   = enable & rise;
    release_d = enable & fall;
  end

  // Auto-repeat: the counter restarts on any press, release or while
  // disabled, so it only advances across cycles where the key is steadily
  // held. It counts to the delay first, then reloads for the period phase.
  // Clearing on the press edge keeps repeat and press in different cycles.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    repeat_d    = 1'b0;
    if (rep_phase_q) begin
      rep_last = PERIOD_LAST;
    end else begin
      rep_last = DELAY_LAST;
    end
    if (!enable || !down_q || toggle) begin
      rep_cnt_d   = RP_ZERO;
      rep_phase_d = 1'b0;
    end else if (rep_cnt_q >= rep_last) begin
      rep_cnt_d   = RP_ZERO;
      rep_phase_d = 1'b1;
      repeat_d    = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + RP_ONE;
    end
  end

  // Synchronizer flops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
    end
  end

  // Debounce counter and accepted level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      db_cnt_q <= DB_ZERO;
      down_q   <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      down_q   <= down_d;
    end
  end

  // Repeat counter and phase.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rep_cnt_q   <= RP_ZERO;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end

  // Pulse output flops.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign key_down    = down_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Conditions KEY_COUNT raw active-low push-buttons into debounced levels and
// press / release / auto-repeat pulses. Each key is handled by an independent
// key_channel, so simultaneous events produce simultaneous pulses.
//
// Ports
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   enable      in   1 = pulse outputs allowed
//   key_n       in   raw active-low buttons (bit 3 = game start)
//   key_down    out  debounced levels, 1 = held
//   key_press   out  one-cycle press pulses
//   key_release out  one-cycle release pulses
//   key_repeat  out  one-cycle auto-repeat pulses
// -----------------------------------------------------------------------------
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [KEY_COUNT-1:0] key_n,
  output logic [KEY_COUNT-1:0] key_down,
  output logic [KEY_COUNT-1:0] key_press,
  output logic [KEY_COUNT-1:0] key_release,
  output logic [KEY_COUNT-1:0] key_repeat
);

  for (genvar g = 0; g < KEY_COUNT; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_key_channel (
      .clock       (clock),
      .resetn      (resetn),
      .enable      (enable),
      .key_n       (key_n[g]),
      .key_down    (key_down[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
      .key_repeat  (key_repeat[g])
    );
  end

endmodule
